// File: rtl/block_serializer.sv
// block_serializer: captures a BLOCK_W-bit block and emits it LSB first, one bit per valid/ready transfer,
// with per-word and end-of-block pulses.
module block_serializer #(
  parameter int BLOCK_W = 512,
  parameter int WORD_W  = 32,
  localparam int CW = $clog2(WORD_W) + 1,
  localparam int OW = $clog2(BLOCK_W) + 1
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [BLOCK_W-1:0] iBlock,
  input  logic               iAbort,
  input  logic               iReady,
  output logic               oBit,
  output logic               oBit_valid,
  output logic [CW-1:0]      oBit_counter,
  output logic [OW-1:0]      oWord_offset,
  output logic               oWord_done,
  output logic               oBusy,
  output logic               oDone
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t             state_q;
  logic [BLOCK_W-1:0] shadow_q;
  logic [CW-1:0]      cnt_q;
  logic [OW-1:0]      off_q;
  logic               word_done_q;
  logic               last_bit, last_word;
  assign last_bit  = cnt_q == CW'(WORD_W - 1);
  assign last_word = off_q == OW'(BLOCK_W - WORD_W);
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      word_done_q <= 1'b0;
    end else if (iAbort) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      case (state_q)
        IDLE: if (iStart) begin
          shadow_q <= iBlock;
          cnt_q    <= '0;
          off_q    <= '0;
          state_q  <= SEND;
        end
        SEND: if (iReady) begin
          shadow_q <= shadow_q >> 1;
          if (last_bit) begin
            cnt_q       <= '0;
            off_q       <= off_q + OW'(WORD_W);
            word_done_q <= 1'b1;
            if (last_word) state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          off_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Outputs are pure decodes of registered state, so iReady never reaches oBit/oBit_valid.
  assign oBit         = shadow_q[0];
  assign oBit_valid   = state_q == SEND;
  assign oBusy        = state_q == SEND;
  assign oDone        = state_q == DONE;
  assign oWord_done   = word_done_q;
  assign oBit_counter = cnt_q;
  assign oWord_offset = off_q;
endmodule
